// File: rtl/i2s_sample_arbiter_if.sv
// Sample-port bundle between the two audio requesters, the arbiter and the I2S DAC transmitter.
// The arbiter takes the slave side; whoever drives requests and consumes samples takes the master side.
interface i2s_sample_arbiter_if;
    logic               enable_i;
    logic [2:0]         atten_i;
    logic [1:0]         req_i;
    logic [1:0]         gnt_o;
    logic [1:0]         valid_i;
    logic [1:0]         ack_o;
    logic signed [23:0] src0_l_i;
    logic signed [23:0] src0_r_i;
    logic signed [23:0] src1_l_i;
    logic signed [23:0] src1_r_i;
    logic signed [23:0] sample_l_o;
    logic signed [23:0] sample_r_o;
    logic               sample_ready_o;
    logic               clear_underrun_i;
    logic [7:0]         underrun_cnt_o;

    modport slave (
        input  enable_i, atten_i, req_i, valid_i,
        input  src0_l_i, src0_r_i, src1_l_i, src1_r_i, clear_underrun_i,
        output gnt_o, ack_o, sample_l_o, sample_r_o, sample_ready_o, underrun_cnt_o
    );

    modport master (
        output enable_i, atten_i, req_i, valid_i,
        output src0_l_i, src0_r_i, src1_l_i, src1_r_i, clear_underrun_i,
        input  gnt_o, ack_o, sample_l_o, sample_r_o, sample_ready_o, underrun_cnt_o
    );
endinterface

// File: rtl/i2s_sample_arbiter.sv
// Frame-rate scheduler sharing the I2S DAC sample port between the alarm tone (src0, priority)
// and the distance beep (src1): one fetch per frame, attenuation, muting and underrun counting.
module i2s_sample_arbiter #(
    parameter int FRAME_CYCLES = 384
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    i2s_sample_arbiter_if.slave  bus
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] FETCH = CW'(FRAME_CYCLES - 2);

    logic [CW-1:0]      cnt;
    logic [1:0]         gnt;
    logic [1:0]         ack;
    logic               ready;
    logic signed [23:0] hold_l;
    logic signed [23:0] hold_r;
    logic signed [23:0] sample_l;
    logic signed [23:0] sample_r;
    logic [7:0]         underrun_cnt;

    logic               is_last;
    logic               is_fetch;
    logic               owner_req;
    logic               owner_valid;
    logic               underrun;
    logic signed [23:0] owner_l;
    logic signed [23:0] owner_r;

    assign is_last     = bus.enable_i && (cnt == LAST);
    assign is_fetch    = bus.enable_i && (cnt == FETCH);
    assign owner_req   = |(bus.req_i & gnt);
    assign owner_valid = |(bus.valid_i & gnt);
    assign underrun    = is_fetch && owner_req && !owner_valid;
    assign owner_l     = gnt[1] ? bus.src1_l_i : bus.src0_l_i;
    assign owner_r     = gnt[1] ? bus.src1_r_i : bus.src0_r_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt <= '0;
        end else if (!bus.enable_i || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Ownership only changes at the frame boundary, so a higher-priority request waits for it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            gnt <= 2'b00;
        end else if (!bus.enable_i) begin
            gnt <= 2'b00;
        end else if (is_last) begin
            if (bus.req_i[0]) begin
                gnt <= 2'b01;
            end else if (bus.req_i[1]) begin
                gnt <= 2'b10;
            end else begin
                gnt <= 2'b00;
            end
        end
    end

    // A frame without a valid owner sample is fetched as silence.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_l <= '0;
            hold_r <= '0;
            ack    <= 2'b00;
        end else begin
            ack <= 2'b00;
            if (is_fetch) begin
                if (owner_req && owner_valid) begin
                    hold_l <= owner_l;
                    hold_r <= owner_r;
                    ack    <= gnt;
                end else begin
                    hold_l <= '0;
                    hold_r <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_l <= '0;
            sample_r <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= is_last;
            if (is_last) begin
                sample_l <= hold_l >>> bus.atten_i;
                sample_r <= hold_r >>> bus.atten_i;
            end
        end
    end

    // A clear coinciding with an underrun keeps that underrun in the fresh count.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            underrun_cnt <= 8'd0;
        end else if (bus.clear_underrun_i) begin
            underrun_cnt <= underrun ? 8'd1 : 8'd0;
        end else if (underrun && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    assign bus.gnt_o          = bus.enable_i ? gnt : 2'b00;
    assign bus.ack_o          = bus.enable_i ? ack : 2'b00;
    assign bus.sample_ready_o = bus.enable_i ? ready : 1'b0;
    assign bus.sample_l_o     = sample_l;
    assign bus.sample_r_o     = sample_r;
    assign bus.underrun_cnt_o = underrun_cnt;

endmodule

// File: tb/tb_i2s_sample_arbiter.sv
// Bench for i2s_sample_arbiter: a short-frame instance for arbitration/fetch/underrun behaviour
// and a full-rate instance for the 384-cycle strobe period.
module tb_i2s_sample_arbiter;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } sample_t;

    logic clk = 1'b0;
    logic reset_n;
    logic reset384_n;

    int checks = 0;
    int errors = 0;
    sample_t exp_q[$];

    int since384 = 0;
    int last384 = 0;
    int strobes384 = 0;

    always #5 clk = ~clk;

    i2s_sample_arbiter_if bus8 ();
    i2s_sample_arbiter_if bus384 ();

    i2s_sample_arbiter #(.FRAME_CYCLES(8)) dut8 (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus8.slave)
    );

    i2s_sample_arbiter #(.FRAME_CYCLES(384)) dut384 (
        .clk_i    (clk),
        .reset_ni (reset384_n),
        .bus      (bus384.slave)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        sample_t e;
        if (bus8.sample_ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got strobe, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check_output("sample_l", 32'($unsigned(bus8.sample_l_o)), 32'(e.l));
                check_output("sample_r", 32'($unsigned(bus8.sample_r_o)), 32'(e.r));
            end
        end
    end

    always @(posedge clk or negedge reset384_n) begin
        if (!reset384_n) since384 <= 0;
        else             since384 <= since384 + 1;
    end

    always @(negedge clk) begin
        if (bus384.sample_ready_o === 1'b1) begin
            check_output("rate384_period", 32'(since384 - last384), 32'd384);
            check_output("rate384_l", 32'($unsigned(bus384.sample_l_o)), 32'd0);
            check_output("rate384_r", 32'($unsigned(bus384.sample_r_o)), 32'd0);
            check_output("rate384_gnt", 32'(bus384.gnt_o), 32'd0);
            last384    <= since384;
            strobes384 <= strobes384 + 1;
        end
    end

    // Runs one 8-cycle frame starting at cnt==0; req changes at cnt==3, clear pulses at clear_at.
    task automatic apply_frame(input logic [1:0] exp_gnt, input logic [1:0] req_mid,
                               input logic [1:0] exp_ack, input logic [23:0] exp_l,
                               input logic [23:0] exp_r, input int clear_at);
        sample_t e;
        e.l = exp_l;
        e.r = exp_r;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            check_output("gnt", 32'(bus8.gnt_o), 32'(exp_gnt));
            check_output("ack", 32'(bus8.ack_o), (i == 7) ? 32'(exp_ack) : 32'd0);
            if (i == 3) bus8.req_i = req_mid;
            bus8.clear_underrun_i = (i == clear_at);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt"}, 32'(bus8.gnt_o), 32'd0);
        check_output({tag, "_ack"}, 32'(bus8.ack_o), 32'd0);
        check_output({tag, "_ready"}, 32'(bus8.sample_ready_o), 32'd0);
        check_output({tag, "_l"}, 32'($unsigned(bus8.sample_l_o)), 32'd0);
        check_output({tag, "_r"}, 32'($unsigned(bus8.sample_r_o)), 32'd0);
        check_output({tag, "_underruns"}, 32'(bus8.underrun_cnt_o), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        reset384_n = 1'b0;
        bus8.enable_i = 1'b0;
        bus8.atten_i  = 3'd0;
        bus8.req_i    = 2'b00;
        bus8.valid_i  = 2'b00;
        bus8.src0_l_i = '0;
        bus8.src0_r_i = '0;
        bus8.src1_l_i = '0;
        bus8.src1_r_i = '0;
        bus8.clear_underrun_i = 1'b0;
        bus384.enable_i = 1'b1;
        bus384.atten_i  = 3'd0;
        bus384.req_i    = 2'b00;
        bus384.valid_i  = 2'b00;
        bus384.src0_l_i = '0;
        bus384.src0_r_i = '0;
        bus384.src1_l_i = '0;
        bus384.src1_r_i = '0;
        bus384.clear_underrun_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n       = 1'b1;
        reset384_n    = 1'b1;
        bus8.enable_i = 1'b1;

        apply_frame(2'b00, 2'b00, 2'b00, 24'h000000, 24'h000000, -1);
        bus8.src1_l_i = 24'h123456;
        bus8.src1_r_i = 24'hFEDCBA;
        bus8.valid_i  = 2'b10;
        apply_frame(2'b00, 2'b10, 2'b00, 24'h000000, 24'h000000, -1);
        apply_frame(2'b10, 2'b10, 2'b10, 24'h123456, 24'hFEDCBA, -1);
        apply_frame(2'b10, 2'b10, 2'b10, 24'h123456, 24'hFEDCBA, -1);

        bus8.src0_l_i = 24'h800000;
        bus8.src0_r_i = 24'h400000;
        bus8.valid_i  = 2'b11;
        apply_frame(2'b10, 2'b11, 2'b10, 24'h123456, 24'hFEDCBA, -1);
        bus8.atten_i = 3'd2;
        apply_frame(2'b01, 2'b11, 2'b01, 24'hE00000, 24'h100000, -1);

        apply_frame(2'b01, 2'b10, 2'b00, 24'h000000, 24'h000000, -1);
        check_output("drop_underruns", 32'(bus8.underrun_cnt_o), 32'd0);
        apply_frame(2'b10, 2'b10, 2'b10, 24'h048D15, 24'hFFB72E, -1);

        bus8.atten_i = 3'd0;
        bus8.valid_i = 2'b00;
        apply_frame(2'b10, 2'b01, 2'b00, 24'h000000, 24'h000000, -1);
        check_output("no_req_underruns", 32'(bus8.underrun_cnt_o), 32'd0);
        for (int n = 1; n <= 300; n++) begin
            apply_frame(2'b01, 2'b01, 2'b00, 24'h000000, 24'h000000, -1);
            if (n == 10)  check_output("underruns_10", 32'(bus8.underrun_cnt_o), 32'd10);
            if (n == 255) check_output("underruns_255", 32'(bus8.underrun_cnt_o), 32'd255);
        end
        check_output("underruns_sat", 32'(bus8.underrun_cnt_o), 32'd255);
        apply_frame(2'b01, 2'b01, 2'b00, 24'h000000, 24'h000000, 6);
        check_output("clear_with_underrun", 32'(bus8.underrun_cnt_o), 32'd1);
        apply_frame(2'b01, 2'b00, 2'b00, 24'h000000, 24'h000000, 2);
        check_output("clear_alone", 32'(bus8.underrun_cnt_o), 32'd0);

        bus8.valid_i = 2'b01;
        apply_frame(2'b00, 2'b01, 2'b00, 24'h000000, 24'h000000, -1);
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_output("in_reset_ack", 32'(bus8.ack_o), 32'd0);
            check_output("in_reset_ready", 32'(bus8.sample_ready_o), 32'd0);
        end
        reset_n = 1'b1;
        apply_frame(2'b00, 2'b01, 2'b00, 24'h000000, 24'h000000, -1);
        apply_frame(2'b01, 2'b01, 2'b01, 24'h800000, 24'h400000, -1);

        repeat (3) @(posedge clk);
        #1;
        bus8.enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("disabled_gnt", 32'(bus8.gnt_o), 32'd0);
            check_output("disabled_ack", 32'(bus8.ack_o), 32'd0);
            check_output("disabled_ready", 32'(bus8.sample_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        bus8.enable_i = 1'b1;
        apply_frame(2'b00, 2'b01, 2'b00, 24'h000000, 24'h000000, -1);
        apply_frame(2'b01, 2'b01, 2'b01, 24'h800000, 24'h400000, -1);

        @(negedge clk);
        #1;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check_output("rate384_seen", 32'(strobes384 >= 3), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
